// File: rtl/segway_pkg.sv
// Shared defaults and helpers for the segway balance datapath.
// Width-12 tuning constants plus a signed saturation helper.
package segway_pkg;

  localparam int MIN_DUTY_DEF        = 'h3C0;
  localparam int LOW_TORQUE_BAND_DEF = 'h3C;
  localparam int GAIN_MULT_DEF       = 'h4;
  localparam int TOO_FAST_THRESH_DEF = 1536;

  function automatic int saturate(
    input int v,
    input int w
  );
    int hi;
    int lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/soft_start_tmr.sv
// Soft-start ramp: prescaled, saturating timer that restarts
// whenever the rider steps off.
module soft_start_tmr #(
  parameter int SS_W        = 8,
  parameter int SS_PRESCALE = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pwr_up,
  output logic [SS_W-1:0] ss_tmr
);

  localparam int PW =
    (SS_PRESCALE > 1) ? $clog2(SS_PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(SS_PRESCALE - 1);

  logic [PW-1:0] pre;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre    <= '0;
      ss_tmr <= '0;
    end else if (!pwr_up) begin
      pre    <= '0;
      ss_tmr <= '0;
    end else if (pre == PRE_MAX) begin
      pre <= '0;
      if (ss_tmr != '1)
        ss_tmr <= ss_tmr + SS_W'(1);
    end else begin
      pre <= pre + PW'(1);
    end
  end

endmodule

// File: rtl/segway_balance_math.sv
// Two-stage balance math: soft-start scaled PID plus steering,
// deadzone/gain shaping, saturation and a filtered overspeed flag.
module segway_balance_math
  import segway_pkg::*;
#(
  parameter int W               = 12,
  parameter int SS_W            = 8,
  parameter int SS_PRESCALE     = 4,
  parameter int MIN_DUTY        = MIN_DUTY_DEF,
  parameter int LOW_TORQUE_BAND = LOW_TORQUE_BAND_DEF,
  parameter int GAIN_MULT       = GAIN_MULT_DEF,
  parameter int TOO_FAST_THRESH = TOO_FAST_THRESH_DEF,
  parameter int TF_CNT          = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                vld_in,
  input  logic signed [W-1:0] PID_cntrl,
  input  logic        [W-1:0] steer_pot,
  input  logic                en_steer,
  input  logic                pwr_up,
  output logic signed [W-1:0] lft_spd,
  output logic signed [W-1:0] rght_spd,
  output logic                vld_out,
  output logic                too_fast,
  output logic     [SS_W-1:0] ss_tmr
);

  localparam logic [W-1:0] STEER_LO  = W'(1 << (W - 3));
  localparam logic [W-1:0] STEER_HI  = W'(7 << (W - 3));
  localparam logic [W-1:0] STEER_MID = W'((1 << (W - 1)) - 1);
  localparam int           CW        = $clog2(TF_CNT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TF_CNT);

  function automatic logic signed [W-1:0] scale_pid(
    input logic signed [W-1:0] pid,
    input logic     [SS_W-1:0] ss
  );
    logic signed [W+SS_W:0] prod;
    prod = (W+SS_W+1)'(pid) * $signed((W+SS_W+1)'(ss));
    return W'(prod >>> SS_W);
  endfunction

  function automatic logic signed [W-1:0] scale_steer(
    input logic [W-1:0] pot
  );
    logic        [W-1:0] lim;
    logic signed [W+3:0] d;
    if (pot < STEER_LO)      lim = STEER_LO;
    else if (pot > STEER_HI) lim = STEER_HI;
    else                     lim = pot;
    d = $signed((W+4)'(lim)) - $signed((W+4)'(STEER_MID));
    return W'((d + (d <<< 1)) >>> 4);
  endfunction

  // Large torques jump the motor deadzone; small ones get extra gain.
  function automatic logic signed [W-1:0] shape(
    input logic signed [W:0] t
  );
    int ti;
    int r;
    ti = int'(t);
    if (ti >= LOW_TORQUE_BAND)       r = ti + MIN_DUTY;
    else if (ti <= -LOW_TORQUE_BAND) r = ti - MIN_DUTY;
    else                             r = ti * GAIN_MULT;
    return W'(saturate(r, W));
  endfunction

  soft_start_tmr #(
    .SS_W       (SS_W),
    .SS_PRESCALE(SS_PRESCALE)
  ) u_ss (
    .clk   (clk),
    .rst_n (rst_n),
    .pwr_up(pwr_up),
    .ss_tmr(ss_tmr)
  );

  logic                s1_vld;
  logic signed [W-1:0] s1_pid;
  logic signed [W-1:0] s1_steer;
  logic                s1_pwr;
  logic                s1_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld   <= 1'b0;
      s1_pid   <= '0;
      s1_steer <= '0;
      s1_pwr   <= 1'b0;
      s1_en    <= 1'b0;
    end else begin
      s1_vld <= vld_in;
      if (vld_in) begin
        s1_pid   <= scale_pid(PID_cntrl, ss_tmr);
        s1_steer <= scale_steer(steer_pot);
        s1_pwr   <= pwr_up;
        s1_en    <= en_steer;
      end
    end
  end

  logic signed [W:0] steer_t;
  logic signed [W:0] lft_t;
  logic signed [W:0] rght_t;
  logic              pwr_ok;

  assign steer_t = s1_en ? (W+1)'(s1_steer) : '0;
  assign lft_t   = (W+1)'(s1_pid) + steer_t;
  assign rght_t  = (W+1)'(s1_pid) - steer_t;
  // Power loss while a sample is in flight still zeroes it.
  assign pwr_ok  = s1_pwr && pwr_up;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_out  <= 1'b0;
      lft_spd  <= '0;
      rght_spd <= '0;
    end else begin
      vld_out <= s1_vld;
      if (s1_vld) begin
        lft_spd  <= pwr_ok ? shape(lft_t)  : '0;
        rght_spd <= pwr_ok ? shape(rght_t) : '0;
      end
    end
  end

  logic [CW-1:0] tf_cnt;
  logic [CW-1:0] tf_cnt_nxt;
  logic          over;

  assign over = (lft_spd > TOO_FAST_THRESH) ||
                (rght_spd > TOO_FAST_THRESH);

  always_comb begin
    tf_cnt_nxt = '0;
    if (over)
      tf_cnt_nxt = (tf_cnt == CNT_MAX) ? tf_cnt
                                       : tf_cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tf_cnt   <= '0;
      too_fast <= 1'b0;
    end else if (!pwr_up) begin
      tf_cnt   <= '0;
      too_fast <= 1'b0;
    end else if (vld_out) begin
      tf_cnt   <= tf_cnt_nxt;
      too_fast <= (tf_cnt_nxt == CNT_MAX);
    end
  end

endmodule

// File: tb/tb_segway_balance_math.sv
// Bench for segway_balance_math: directed scenarios plus a random
// stream checked against an integer reference model.
module tb_segway_balance_math;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               vld_in;
  logic signed [11:0] PID_cntrl;
  logic        [11:0] steer_pot;
  logic               en_steer;
  logic               pwr_up;
  logic signed [11:0] lft_spd;
  logic signed [11:0] rght_spd;
  logic               vld_out;
  logic               too_fast;
  logic        [7:0]  ss_tmr;

  int errors = 0;
  int checks = 0;
  int up_cycles;

  segway_balance_math dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .vld_in   (vld_in),
    .PID_cntrl(PID_cntrl),
    .steer_pot(steer_pot),
    .en_steer (en_steer),
    .pwr_up   (pwr_up),
    .lft_spd  (lft_spd),
    .rght_spd (rght_spd),
    .vld_out  (vld_out),
    .too_fast (too_fast),
    .ss_tmr   (ss_tmr)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) up_cycles <= 0;
    else        up_cycles <= pwr_up ? up_cycles + 1 : 0;

  function automatic int model_ss();
    int v;
    v = up_cycles / 4;
    return (v > 255) ? 255 : v;
  endfunction

  function automatic int model_spd(int pid, int ss, int steer,
                                   bit en, bit left);
    int pss, lim, st, t, s;
    pss = (pid * ss) >>> 8;
    lim = (steer < 512) ? 512 : (steer > 3584) ? 3584 : steer;
    st  = ((lim - 2047) * 3) >>> 4;
    t   = !en ? pss : left ? pss + st : pss - st;
    if (t >= 60)       s = t + 960;
    else if (t <= -60) s = t - 960;
    else               s = t * 4;
    if (s > 2047)  s = 2047;
    if (s < -2048) s = -2048;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [11:0] pid, logic [11:0] st, bit en);
    PID_cntrl = pid;
    steer_pot = st;
    en_steer  = en;
    vld_in    = 1'b1;
    tick();
    vld_in    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vld_in = 1'b0; PID_cntrl = '0;
    steer_pot = '0; en_steer = 1'b0; pwr_up = 1'b0;
    repeat (3) tick();
    checks += 5;
    if (lft_spd !== 12'd0) begin errors++;
      $display("FAIL reset_lft got %0d want 0", lft_spd); end
    if (rght_spd !== 12'd0) begin errors++;
      $display("FAIL reset_rght got %0d want 0", rght_spd); end
    if (vld_out !== 1'b0) begin errors++;
      $display("FAIL reset_vld got %b want 0", vld_out); end
    if (too_fast !== 1'b0) begin errors++;
      $display("FAIL reset_tf got %b want 0", too_fast); end
    if (ss_tmr !== 8'd0) begin errors++;
      $display("FAIL reset_ss got %0d want 0", ss_tmr); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ramp();
    pwr_up = 1'b1;
    repeat (3) tick();
    checks++;
    if (ss_tmr !== 8'd0) begin errors++;
      $display("FAIL ramp_3 got %0d want 0", ss_tmr); end
    tick();
    checks++;
    if (ss_tmr !== 8'd1) begin errors++;
      $display("FAIL ramp_4 got %0d want 1", ss_tmr); end
    repeat (1015) tick();
    checks++;
    if (ss_tmr !== 8'hFE) begin errors++;
      $display("FAIL ramp_1019 got %0d want 254", ss_tmr); end
    tick();
    checks++;
    if (ss_tmr !== 8'hFF) begin errors++;
      $display("FAIL ramp_1020 got %0d want 255", ss_tmr); end
    repeat (12) tick();
    checks++;
    if (ss_tmr !== 8'hFF) begin errors++;
      $display("FAIL ramp_sat got %0d want 255", ss_tmr); end
    pwr_up = 1'b0;
    tick();
    checks++;
    if (ss_tmr !== 8'd0) begin errors++;
      $display("FAIL ramp_drop got %0d want 0", ss_tmr); end
    pwr_up = 1'b1;
    repeat (1024) tick();
  endtask

  task automatic test_nominal();
    drive(12'h100, 12'h800, 1'b0);
    checks++;
    if (vld_out !== 1'b0) begin errors++;
      $display("FAIL nom_early got %b want 0", vld_out); end
    tick();
    checks += 3;
    if (vld_out !== 1'b1) begin errors++;
      $display("FAIL nom_vld got %b want 1", vld_out); end
    if (lft_spd !== 12'sd1215) begin errors++;
      $display("FAIL nom_lft got %0d want 1215", lft_spd); end
    if (rght_spd !== 12'sd1215) begin errors++;
      $display("FAIL nom_rght got %0d want 1215", rght_spd); end
    tick();
    checks += 2;
    if (vld_out !== 1'b0) begin errors++;
      $display("FAIL nom_pulse got %b want 0", vld_out); end
    if (lft_spd !== 12'sd1215) begin errors++;
      $display("FAIL nom_hold got %0d want 1215", lft_spd); end
    drive(12'hF00, 12'h800, 1'b0);
    tick();
    checks += 2;
    if (lft_spd !== 12'hB41) begin errors++;
      $display("FAIL neg_lft got %0d want -1215", lft_spd); end
    if (rght_spd !== 12'hB41) begin errors++;
      $display("FAIL neg_rght got %0d want -1215", rght_spd); end
  endtask

  task automatic test_low_band();
    drive(12'h00A, 12'h800, 1'b0);
    tick();
    checks += 2;
    if (lft_spd !== 12'sd36) begin errors++;
      $display("FAIL low_lft got %0d want 36", lft_spd); end
    if (rght_spd !== 12'sd36) begin errors++;
      $display("FAIL low_rght got %0d want 36", rght_spd); end
  endtask

  task automatic test_steering();
    drive(12'h000, 12'hFFF, 1'b1);
    tick();
    checks += 2;
    if (lft_spd !== 12'sd1248) begin errors++;
      $display("FAIL steer_hi_lft got %0d want 1248", lft_spd); end
    if (rght_spd !== -12'sd1248) begin errors++;
      $display("FAIL steer_hi_rght got %0d want -1248", rght_spd); end
    drive(12'h000, 12'h000, 1'b1);
    tick();
    checks += 2;
    if (lft_spd !== -12'sd1248) begin errors++;
      $display("FAIL steer_lo_lft got %0d want -1248", lft_spd); end
    if (rght_spd !== 12'sd1248) begin errors++;
      $display("FAIL steer_lo_rght got %0d want 1248", rght_spd); end
    en_steer = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp_s;
    PID_cntrl = 12'h5FF; steer_pot = 12'h800;
    en_steer = 1'b0; vld_in = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks += 2;
      if (vld_out !== (i >= 2 && i <= 6)) begin errors++;
        $display("FAIL b2b_vld[%0d] got %b", i, vld_out); end
      if (too_fast !== (i == 6)) begin errors++;
        $display("FAIL b2b_tf[%0d] got %b want %b",
                 i, too_fast, i == 6); end
      if (i >= 2 && i <= 6) begin
        exp_s = (i == 6) ? 12'd1215 : 12'h7FF;
        checks += 2;
        if (lft_spd !== exp_s) begin errors++;
          $display("FAIL b2b_lft[%0d] got %0d want %0d",
                   i, lft_spd, exp_s); end
        if (rght_spd !== exp_s) begin errors++;
          $display("FAIL b2b_rght[%0d] got %0d want %0d",
                   i, rght_spd, exp_s); end
      end
      if (i == 4) PID_cntrl = 12'h100;
      if (i == 5) vld_in = 1'b0;
    end
  endtask

  task automatic test_reset_inflight();
    PID_cntrl = 12'h300; vld_in = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks += 5;
    if (lft_spd !== 12'd0) begin errors++;
      $display("FAIL rstf_lft got %0d want 0", lft_spd); end
    if (rght_spd !== 12'd0) begin errors++;
      $display("FAIL rstf_rght got %0d want 0", rght_spd); end
    if (vld_out !== 1'b0) begin errors++;
      $display("FAIL rstf_vld got %b want 0", vld_out); end
    if (too_fast !== 1'b0) begin errors++;
      $display("FAIL rstf_tf got %b want 0", too_fast); end
    if (ss_tmr !== 8'd0) begin errors++;
      $display("FAIL rstf_ss got %0d want 0", ss_tmr); end
    vld_in = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks += 2;
      if (vld_out !== 1'b0) begin errors++;
        $display("FAIL rstf_ghost[%0d] got %b want 0", i, vld_out); end
      if (lft_spd !== 12'd0) begin errors++;
        $display("FAIL rstf_hold[%0d] got %0d want 0", i, lft_spd); end
    end
  endtask

  task automatic test_powerdown();
    PID_cntrl = 12'h100; steer_pot = 12'hFFF;
    en_steer = 1'b1; vld_in = 1'b1;
    tick();
    vld_in = 1'b0; pwr_up = 1'b0;
    tick();
    checks += 3;
    if (vld_out !== 1'b1) begin errors++;
      $display("FAIL pd_vld got %b want 1", vld_out); end
    if (lft_spd !== 12'd0) begin errors++;
      $display("FAIL pd_lft got %0d want 0", lft_spd); end
    if (rght_spd !== 12'd0) begin errors++;
      $display("FAIL pd_rght got %0d want 0", rght_spd); end
    tick();
    checks++;
    if (vld_out !== 1'b0) begin errors++;
      $display("FAIL pd_pulse got %b want 0", vld_out); end
    vld_in = 1'b1;
    tick();
    vld_in = 1'b0; pwr_up = 1'b1;
    tick();
    checks += 2;
    if (vld_out !== 1'b1) begin errors++;
      $display("FAIL pd_cap_vld got %b want 1", vld_out); end
    if (rght_spd !== 12'd0) begin errors++;
      $display("FAIL pd_cap_rght got %0d want 0", rght_spd); end
    en_steer = 1'b0;
    tick();
  endtask

  typedef struct {
    int due;
    int l;
    int r;
  } exp_t;

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    int   cnt_m;
    bit   tf_m;
    int   pid;
    cnt_m = 0; tf_m = 1'b0;
    pwr_up = 1'b1;
    for (int s = 0; s < 700; s++) begin
      tick();
      checks++;
      if (too_fast !== tf_m) begin errors++;
        $display("FAIL rnd_tf[%0d] got %b want %b", s, too_fast, tf_m); end
      if (q.size() > 0 && q[0].due == s) begin
        e = q.pop_front();
        checks += 3;
        if (vld_out !== 1'b1) begin errors++;
          $display("FAIL rnd_vld[%0d] got %b want 1", s, vld_out); end
        if (lft_spd !== 12'(e.l)) begin errors++;
          $display("FAIL rnd_lft[%0d] got %0d want %0d", s, lft_spd, e.l); end
        if (rght_spd !== 12'(e.r)) begin errors++;
          $display("FAIL rnd_rght[%0d] got %0d want %0d", s, rght_spd, e.r); end
        if (e.l > 1536 || e.r > 1536)
          cnt_m = (cnt_m < 4) ? cnt_m + 1 : 4;
        else
          cnt_m = 0;
        tf_m = (cnt_m == 4);
      end else begin
        checks++;
        if (vld_out !== 1'b0) begin errors++;
          $display("FAIL rnd_idle[%0d] got %b want 0", s, vld_out); end
      end
      vld_in    = (s < 695) && ($urandom_range(0, 3) != 0);
      PID_cntrl = 12'($urandom);
      steer_pot = 12'($urandom);
      en_steer  = 1'($urandom);
      if (vld_in) begin
        pid = int'(PID_cntrl);
        e.due = s + 2;
        e.l = model_spd(pid, model_ss(), int'(steer_pot), en_steer, 1'b1);
        e.r = model_spd(pid, model_ss(), int'(steer_pot), en_steer, 1'b0);
        q.push_back(e);
      end
    end
    vld_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_nominal();
    test_low_band();
    test_steering();
    test_back_to_back();
    test_reset_inflight();
    test_powerdown();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
